hack_alu_stage: RTL and testbench

- Registered 16-bit Hack-style ALU stage. Consumes the bitwise gate layer (And16/Or16/Not16 equivalents) and produces result plus zr/ng status flags for the CPU datapath.
- Operands and 6-bit control are accepted on a valid/ready handshake.
- Results are buffered in a 2-entry output queue, so the upstream decode stage can run back-to-back while downstream stalls.

---
 rtl/hack_alu_stage_if.sv | 40 ++++
 rtl/hack_alu_stage.sv | 102 ++++++++++
 tb/tb_hack_alu_stage.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_alu_stage_if.sv
// Valid/ready bundle for hack_alu_stage: operand/control beats in, queued results out.
// With ALU_EXT_FLAGS_EN defined, the result side also carries cout and ovf.
interface hack_alu_stage_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [5:0]       ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;
`ifdef ALU_EXT_FLAGS_EN
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, x, y, ctrl, out_ready,
        input  in_ready, out_valid, out, zr, ng, cout, ovf
    );

    modport slave (
        input  in_valid, x, y, ctrl, out_ready,
        output in_ready, out_valid, out, zr, ng, cout, ovf
    );
`else
    modport master (
        output in_valid, x, y, ctrl, out_ready,
        input  in_ready, out_valid, out, zr, ng
    );

    modport slave (
        input  in_valid, x, y, ctrl, out_ready,
        output in_ready, out_valid, out, zr, ng
    );
`endif
endinterface

// File: rtl/hack_alu_stage.sv
// Registered Hack ALU stage feeding a 2-entry result queue on valid/ready handshakes.
// Define ALU_EXT_FLAGS_EN to also queue the adder carry-out (cout) and signed overflow (ovf).
module hack_alu_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    hack_alu_stage_if.slave bus
);
`ifdef ALU_EXT_FLAGS_EN
    localparam int EW = WIDTH + 4;
`else
    localparam int EW = WIDTH + 2;
`endif
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] x1, x2, y1, y2, sum, r, res;
`ifdef ALU_EXT_FLAGS_EN
    logic             carry;
    logic             sumOvf;
`endif
    logic [EW-1:0]    newEntry;
    logic [EW-1:0]    headEntry_q, headEntry_d;
    logic [EW-1:0]    spareEntry_q, spareEntry_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    // Datapath: zero/negate each operand, add or AND them, optionally negate the result.
    always_comb begin
        x1 = bus.ctrl[5] ? '0 : bus.x;
        x2 = bus.ctrl[4] ? ~x1 : x1;
        y1 = bus.ctrl[3] ? '0 : bus.y;
        y2 = bus.ctrl[2] ? ~y1 : y1;
`ifdef ALU_EXT_FLAGS_EN
        {carry, sum} = {1'b0, x2} + {1'b0, y2};
        sumOvf = (x2[WIDTH-1] == y2[WIDTH-1]) && (sum[WIDTH-1] != x2[WIDTH-1]);
`else
        sum = x2 + y2;
`endif
        r   = bus.ctrl[1] ? sum : (x2 & y2);
        res = bus.ctrl[0] ? ~r : r;
`ifdef ALU_EXT_FLAGS_EN
        newEntry = {res, (res == '0), res[WIDTH-1], bus.ctrl[1] & carry, bus.ctrl[1] & sumOvf};
`else
        newEntry = {res, (res == '0), res[WIDTH-1]};
`endif
    end

    assign bus.in_ready  = (count_q != CW'(DEPTH));
    assign bus.out_valid = (count_q != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    assign bus.out = headEntry_q[EW-1 -: WIDTH];
    assign bus.zr  = headEntry_q[EW-WIDTH-1];
    assign bus.ng  = headEntry_q[EW-WIDTH-2];
`ifdef ALU_EXT_FLAGS_EN
    assign bus.cout = headEntry_q[1];
    assign bus.ovf  = headEntry_q[0];
`endif

    // The head register is the output; it keeps its last value once the queue runs empty.
    always_comb begin
        headEntry_d  = headEntry_q;
        spareEntry_d = spareEntry_q;
        count_d      = count_q;
        unique case ({push, pop})
            2'b10: begin
                count_d = count_q + 1'b1;
                if (count_q == '0) begin
                    headEntry_d = newEntry;
                end else begin
                    spareEntry_d = newEntry;
                end
            end
            2'b01: begin
                count_d = count_q - 1'b1;
                if (count_q == CW'(DEPTH)) begin
                    headEntry_d = spareEntry_q;
                end
            end
            2'b11: begin
                headEntry_d = newEntry;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            headEntry_q  <= '0;
            spareEntry_q <= '0;
            count_q      <= '0;
        end else begin
            headEntry_q  <= headEntry_d;
            spareEntry_q <= spareEntry_d;
            count_q      <= count_d;
        end
    end
endmodule

// File: tb/tb_hack_alu_stage.sv
// Randomized bench for hack_alu_stage against an arithmetic reference model and result queue.
// Build with ALU_EXT_FLAGS_EN defined to also exercise cout/ovf.
module tb_hack_alu_stage;
    localparam int WIDTH = 16;
`ifdef ALU_EXT_FLAGS_EN
    localparam int BW = WIDTH + 6;
`else
    localparam int BW = WIDTH + 4;
`endif

    typedef struct packed {
        logic [15:0] res;
        logic        zr;
        logic        ng;
        logic        cout;
        logic        ovf;
    } entry_t;

    logic   clk = 1'b0;
    logic   reset;
    int     checks = 0;
    int     errors = 0;
    entry_t expQ[$];
    entry_t lastHead;

    hack_alu_stage_if #(.WIDTH(WIDTH)) busIf ();

    hack_alu_stage #(.WIDTH(WIDTH), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    always #5 clk = ~clk;

    // Reference ALU using plain integer arithmetic on 16-bit values.
    function automatic entry_t aluModel(logic [15:0] xv, logic [15:0] yv, logic [5:0] c);
        int unsigned a, b, r;
        int          sa, sb;
        entry_t      e;
        a = c[5] ? 0 : int'(xv);
        if (c[4]) a = 65535 - a;
        b = c[3] ? 0 : int'(yv);
        if (c[2]) b = 65535 - b;
        r = c[1] ? (a + b) % 65536 : (a & b);
        if (c[0]) r = 65535 - r;
        sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
        sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
        e.res  = r[15:0];
        e.zr   = (r == 0);
        e.ng   = (r >= 32768);
        e.cout = c[1] && (a + b >= 65536);
        e.ovf  = c[1] && ((sa + sb > 32767) || (sa + sb < -32768));
        return e;
    endfunction

    function automatic logic [BW-1:0] expectedBundle();
        entry_t h;
        logic   rdy, vld;
        h   = (expQ.size() != 0) ? expQ[0] : lastHead;
        rdy = (expQ.size() != 2);
        vld = (expQ.size() != 0);
`ifdef ALU_EXT_FLAGS_EN
        return {rdy, vld, h.res, h.zr, h.ng, h.cout, h.ovf};
`else
        return {rdy, vld, h.res, h.zr, h.ng};
`endif
    endfunction

    function automatic logic [BW-1:0] observedBundle();
`ifdef ALU_EXT_FLAGS_EN
        return {busIf.in_ready, busIf.out_valid, busIf.out, busIf.zr, busIf.ng, busIf.cout, busIf.ovf};
`else
        return {busIf.in_ready, busIf.out_valid, busIf.out, busIf.zr, busIf.ng};
`endif
    endfunction

    task automatic applyStimulus(logic v, logic [15:0] xv, logic [15:0] yv, logic [5:0] c, logic rdy);
        busIf.in_valid  = v;
        busIf.x         = xv;
        busIf.y         = yv;
        busIf.ctrl      = c;
        busIf.out_ready = rdy;
    endtask

    // Advance one clock edge and update the queue model from the model's own occupancy.
    task automatic tick();
        bit     doPush, doPop;
        entry_t e;
        doPush = !reset && busIf.in_valid && (expQ.size() != 2);
        doPop  = !reset && busIf.out_ready && (expQ.size() != 0);
        e      = aluModel(busIf.x, busIf.y, busIf.ctrl);
        @(posedge clk);
        if (reset) begin
            expQ.delete();
            lastHead = '0;
        end else begin
            if (doPop) lastHead = expQ.pop_front();
            if (doPush) expQ.push_back(e);
        end
        #1;
    endtask

    task automatic drain();
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(1'b1, 16'h1234, 16'h4321, 6'b000010, 1'b1);
        repeat (2) tick();
        reset = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        checks++;
        if ({busIf.in_ready, busIf.out_valid, busIf.out, busIf.zr, busIf.ng} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state got rdy=%b vld=%b out=%h zr=%b ng=%b exp 1 0 0000 0 0",
                     busIf.in_ready, busIf.out_valid, busIf.out, busIf.zr, busIf.ng);
        end
        tick();
        checks++;
        if (observedBundle() !== expectedBundle()) begin
            errors++;
            $display("[TB] FAIL reset_no_accept got=%h exp=%h", observedBundle(), expectedBundle());
        end
    endtask

    task automatic test_directed();
        logic [15:0] dx[4]   = '{16'h0005, 16'h00F0, 16'h00F0, 16'h0000};
        logic [15:0] dy[4]   = '{16'h0003, 16'h0F00, 16'h0F00, 16'h1234};
        logic [5:0]  dc[4]   = '{6'b000010, 6'b010101, 6'b101010, 6'b001110};
        logic [15:0] dOut[4] = '{16'h0008, 16'h0FF0, 16'h0000, 16'hFFFF};
        logic        dZr[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        dNg[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, dx[i], dy[i], dc[i], 1'b1);
            tick();
            checks++;
            if ({busIf.out_valid, busIf.out, busIf.zr, busIf.ng} !== {1'b1, dOut[i], dZr[i], dNg[i]}) begin
                errors++;
                $display("[TB] FAIL directed_%0d got vld=%b out=%h zr=%b ng=%b exp 1 %h %b %b", i,
                         busIf.out_valid, busIf.out, busIf.zr, busIf.ng, dOut[i], dZr[i], dNg[i]);
            end
        end
        drain();
    endtask

`ifdef ALU_EXT_FLAGS_EN
    task automatic test_ext_flags();
        logic [15:0] ex[2]   = '{16'hFFFF, 16'h7FFF};
        logic [15:0] eOut[2] = '{16'h0000, 16'h8000};
        logic [3:0]  eFlg[2] = '{4'b1010, 4'b0101};
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, ex[i], 16'h0001, 6'b000010, 1'b1);
            tick();
            checks++;
            if ({busIf.out, busIf.zr, busIf.ng, busIf.cout, busIf.ovf} !== {eOut[i], eFlg[i]}) begin
                errors++;
                $display("[TB] FAIL ext_flags_%0d got out=%h zr/ng/cout/ovf=%b%b%b%b exp %h %b", i,
                         busIf.out, busIf.zr, busIf.ng, busIf.cout, busIf.ovf, eOut[i], eFlg[i]);
            end
        end
        drain();
    endtask
`endif

    task automatic test_backpressure();
        logic [15:0] xs[3], ys[3];
        logic [5:0]  cs[3];
        logic [15:0] got[$];
        bit          pending = 1'b1;
        for (int i = 0; i < 3; i++) begin
            xs[i] = 16'($urandom);
            ys[i] = 16'($urandom);
            cs[i] = 6'($urandom);
            checks++;
            if (busIf.in_ready !== (i < 2)) begin
                errors++;
                $display("[TB] FAIL bp_in_ready_%0d got=%b exp=%b", i, busIf.in_ready, (i < 2));
            end
            applyStimulus(1'b1, xs[i], ys[i], cs[i], 1'b0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (observedBundle() !== expectedBundle()) begin
                errors++;
                $display("[TB] FAIL bp_cycle_%0d got=%h exp=%h", i, observedBundle(), expectedBundle());
            end
            if (busIf.out_valid === 1'b1) got.push_back(busIf.out);
            applyStimulus(pending, xs[2], ys[2], cs[2], 1'b1);
            if (pending && expQ.size() != 2) pending = 1'b0;
            tick();
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("[TB] FAIL bp_delivered_count got=%0d exp=3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got[k] !== aluModel(xs[k], ys[k], cs[k]).res) begin
                    errors++;
                    $display("[TB] FAIL bp_order_%0d got=%h exp=%h", k, got[k], aluModel(xs[k], ys[k], cs[k]).res);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 16'($urandom), 16'($urandom), 6'($urandom), 1'b0);
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busIf.in_ready !== 1'b1 || observedBundle() !== expectedBundle()) begin
                errors++;
                $display("[TB] FAIL b2b_cycle_%0d got=%h exp=%h", i, observedBundle(), expectedBundle());
            end
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 6'($urandom), 1'b1);
            tick();
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (observedBundle() !== expectedBundle()) begin
                errors++;
                $display("[TB] FAIL b2b_drain_%0d got=%h exp=%h", i, observedBundle(), expectedBundle());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 6'($urandom), 1'b0);
            tick();
        end
        checks++;
        if ({busIf.in_ready, busIf.out_valid} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL midreset_full got rdy=%b vld=%b exp 0 1", busIf.in_ready, busIf.out_valid);
        end
        reset = 1'b1;
        applyStimulus(1'b1, 16'h7777, 16'h1111, 6'b000010, 1'b1);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        checks++;
        if ({busIf.in_ready, busIf.out_valid, busIf.out, busIf.zr, busIf.ng} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midreset_clear got rdy=%b vld=%b out=%h zr=%b ng=%b exp 1 0 0000 0 0",
                     busIf.in_ready, busIf.out_valid, busIf.out, busIf.zr, busIf.ng);
        end
        tick();
        checks++;
        if (observedBundle() !== expectedBundle()) begin
            errors++;
            $display("[TB] FAIL midreset_after got=%h exp=%h", observedBundle(), expectedBundle());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            checks++;
            if (observedBundle() !== expectedBundle()) begin
                errors++;
                $display("[TB] FAIL random_cycle_%0d got=%h exp=%h", i, observedBundle(), expectedBundle());
            end
            applyStimulus(($urandom_range(3) != 0), 16'($urandom), 16'($urandom), 6'($urandom),
                          ($urandom_range(2) != 0));
            tick();
        end
        drain();
        checks++;
        if (observedBundle() !== expectedBundle()) begin
            errors++;
            $display("[TB] FAIL random_final got=%h exp=%h", observedBundle(), expectedBundle());
        end
    endtask

    initial begin
        reset    = 1'b1;
        lastHead = '0;
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        test_reset();
        test_directed();
`ifdef ALU_EXT_FLAGS_EN
        test_ext_flags();
`endif
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout reached at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
